// File: rtl/hazard_pkg.sv
// Shared types and constants for the execute-stage hazard controller.
// Optional perf counters are enabled with the HAZARD_PERF_CNT_EN macro (see hazard_ctrl).
package hazard_pkg;

  // Encoding matches the operand mux3 input order: RF, ResultW, ALUResultM.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } hz_state_t;

  // R15 is the PC; its value never comes from the forwarding network.
  localparam logic [3:0] PC_REG = 4'd15;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Forwarding select for one E-stage source operand. The youngest producer (M) wins over W.
module hazard_fwd_unit
  import hazard_pkg::*;
(
  input  logic [3:0] RAE,
  input  logic [3:0] RdM,
  input  logic [3:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output fwd_sel_t   fwd
);

  // Pick the most recent in-flight writer of this operand, never for the PC.
  always_comb begin
    fwd = FWD_RF;
    if (RAE != PC_REG) begin
      if (RegWriteM && (RdM == RAE))      fwd = FWD_M;
      else if (RegWriteW && (RdW == RAE)) fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing control around the execute stage: operand forwarding,
// load-use stalls, PC-write flushes and a multi-cycle multiply held in E.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  RA1D,
  input  logic [3:0]  RA2D,
  input  logic [3:0]  RA1E,
  input  logic [3:0]  RA2E,
  input  logic [3:0]  RdE,
  input  logic [3:0]  RdM,
  input  logic [3:0]  RdW,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemtoRegE,
  input  logic        BranchTakenE,
  input  logic        PCSrcD,
  input  logic        PCSrcE,
  input  logic        PCSrcM,
  input  logic        PCSrcW,
  input  logic        MulStartE,
  output logic [1:0]  forwardAE,
  output logic [1:0]  forwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        MulDoneE,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
);

  localparam int unsigned CW    = $clog2(MUL_LAT + 1);
  localparam bit          MULTI = (MUL_LAT > 1);
  // First busy-cycle count: the start cycle itself already stalls once.
  localparam logic [CW-1:0] CNT_INIT = CW'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);

  hz_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          mul_start, mulstall, mul_done;
  logic          ldstall, pcpend;
  fwd_sel_t      fwd_a, fwd_b;

  hazard_fwd_unit u_fwd_a (
    .RAE(RA1E), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .fwd(fwd_a)
  );

  hazard_fwd_unit u_fwd_b (
    .RAE(RA2E), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .fwd(fwd_b)
  );

  // A taken branch in E kills the multiply before it starts.
  assign mul_start = MulStartE && !BranchTakenE;

  // Multiply FSM state and down-counter; reset aborts any op in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: count remaining stall cycles, return to IDLE on the done cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (mul_start && MULTI) begin
          state_nxt = MUL_BUSY;
          cnt_nxt   = CNT_INIT;
        end
      end
      MUL_BUSY: begin
        if (cnt != '0) cnt_nxt = cnt - CW'(1);
        else           state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: stall while the multiply is still computing, done on its last cycle.
  always_comb begin
    mulstall = 1'b0;
    mul_done = 1'b0;
    case (state)
      IDLE: begin
        mulstall = mul_start && MULTI;
        mul_done = mul_start && !MULTI;
      end
      MUL_BUSY: begin
        mulstall = (cnt != '0);
        mul_done = (cnt == '0);
      end
      default: ;
    endcase
  end

  // Load-use is suppressed while the multiply freezes the front end.
  assign ldstall = MemtoRegE && RegWriteE && ((RdE == RA1D) || (RdE == RA2D)) && !mulstall;
  assign pcpend  = PCSrcD || PCSrcE || PCSrcM;

  // Stage controls; while reset is low D and E are held as bubbles. Flush beats stall on D.
  always_comb begin
    if (!reset) begin
      forwardAE = FWD_RF;
      forwardBE = FWD_RF;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushM    = 1'b0;
      MulDoneE  = 1'b0;
    end else begin
      forwardAE = fwd_a;
      forwardBE = fwd_b;
      FlushD    = pcpend || PCSrcW || BranchTakenE;
      FlushE    = ldstall || BranchTakenE;
      FlushM    = mulstall;
      StallF    = ldstall || pcpend || mulstall;
      StallD    = (ldstall || mulstall) && !FlushD;
      StallE    = mulstall;
      MulDoneE  = mul_done;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;

  // Saturating perf counters for front-end stall and E/M flush cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallF && (stall_cnt != '1))            stall_cnt <= stall_cnt + 32'd1;
      if ((FlushE || FlushM) && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign StallCnt = stall_cnt;
  assign FlushCnt = flush_cnt;
`else
  assign StallCnt = 32'h0;
  assign FlushCnt = 32'h0;
`endif

endmodule
